// File: rtl/rv32i_hazard_ctrl_mc_if.sv
// Pipeline <-> hazard controller bundle: stage register/handshake observations in,
// stall/flush/forward controls and performance counters out.
interface rv32i_hazard_ctrl_mc_if #(
    parameter int CNTW = 32
);
    logic [4:0]      Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic            RegWriteE, RegWriteM, RegWriteW;
    logic            ResultSrcEb0, PCSrcE, IMemReadyF, DMemReqM, DMemReadyM;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            StallF, StallD, StallE, StallM;
    logic            FlushD, FlushE, FlushW;
    logic            TakeBranchE, MemWaitM, MemErr;
    logic [CNTW-1:0] StallCnt, FlushCnt, LoadUseCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW,
        output ResultSrcEb0, PCSrcE, IMemReadyF, DMemReqM, DMemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, TakeBranchE, MemWaitM, MemErr,
        input  StallCnt, FlushCnt, LoadUseCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  ResultSrcEb0, PCSrcE, IMemReadyF, DMemReqM, DMemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, TakeBranchE, MemWaitM, MemErr,
        output StallCnt, FlushCnt, LoadUseCnt
    );
endinterface

// File: rtl/rv32i_hazard_ctrl_mc.sv
// Hazard/stall controller for a 5-stage RV32I pipeline with variable-latency memories,
// optional M/W forwarding, a data-memory wait FSM with timeout, and saturating counters.
module rv32i_hazard_ctrl_mc #(
    parameter int FWD_EN  = 1,
    parameter int CNTW    = 32,
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input logic                   clk,
    input logic                   rst,
    rv32i_hazard_ctrl_mc_if.slave hz
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [TOW-1:0]  tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNTW-1:0] lu_cnt_q, lu_cnt_d;
    logic            memstall, rawstall, load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic wm, input logic ww);
        if (wm && rdm != 5'd0 && rs == rdm) return 2'b10;
        if (ww && rdw != 5'd0 && rs == rdw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c, input logic en);
        return (en && c != '1) ? c + CNTW'(1) : c;
    endfunction

    assign memstall = hz.DMemReqM & ~hz.DMemReadyM;

    // Without forwarding, any producer still in E or M must be waited out in D.
    always_comb begin
        if (FWD_EN != 0) begin
            rawstall = hz.ResultSrcEb0 && hz.RdE != 5'd0 &&
                       (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
        end else begin
            rawstall = (hz.Rs1D != 5'd0 && ((hz.RegWriteE && hz.Rs1D == hz.RdE) ||
                                            (hz.RegWriteM && hz.Rs1D == hz.RdM))) ||
                       (hz.Rs2D != 5'd0 && ((hz.RegWriteE && hz.Rs2D == hz.RdE) ||
                                            (hz.RegWriteM && hz.Rs2D == hz.RdM)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (memstall)       state_d = WAIT;
            WAIT: if (hz.DMemReadyM)  state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        hz.StallF      = 1'b0;
        hz.StallD      = 1'b0;
        hz.StallE      = 1'b0;
        hz.StallM      = 1'b0;
        hz.FlushD      = 1'b0;
        hz.FlushE      = 1'b0;
        hz.FlushW      = 1'b0;
        hz.TakeBranchE = 1'b0;
        load_use       = 1'b0;
        hz.MemWaitM    = (state_q == WAIT);
        if (memstall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.TakeBranchE = 1'b1;
            hz.FlushD      = 1'b1;
            hz.FlushE      = 1'b1;
            hz.StallF      = ~hz.IMemReadyF;
        end else if (rawstall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
            load_use  = hz.ResultSrcEb0;
        end else if (!hz.IMemReadyF) begin
            hz.StallF = 1'b1;
            hz.FlushD = 1'b1;
        end
        hz.ForwardAE = (FWD_EN != 0) ?
            fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : 2'b00;
        hz.ForwardBE = (FWD_EN != 0) ?
            fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW) : 2'b00;
    end

    // Timeout counts completed WAIT cycles; it is zero whenever the FSM is idle.
    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT && !hz.DMemReadyM) begin
            tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TOW'(1);
        end
        err_d       = err_q | ((TIMEOUT != 0) && (tmo_q == TOW'(TIMEOUT)));
        stall_cnt_d = sat_inc(stall_cnt_q, hz.StallF | hz.StallD | hz.StallM);
        flush_cnt_d = sat_inc(flush_cnt_q, hz.TakeBranchE);
        lu_cnt_d    = sat_inc(lu_cnt_q, load_use);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign hz.MemErr     = err_q;
    assign hz.StallCnt   = stall_cnt_q;
    assign hz.FlushCnt   = flush_cnt_q;
    assign hz.LoadUseCnt = lu_cnt_q;
endmodule

// File: tb/tb_rv32i_hazard_ctrl_mc.sv
// Two controllers (forwarding/timeout=4/16-bit counters and stall-only/no-timeout/4-bit
// counters) share one stimulus stream; a queue-based scoreboard checks both each cycle.
module tb_rv32i_hazard_ctrl_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_hazard_ctrl_mc_if #(.CNTW(16)) if_a ();
    rv32i_hazard_ctrl_mc_if #(.CNTW(4))  if_b ();

    rv32i_hazard_ctrl_mc #(.FWD_EN(1), .CNTW(16), .TIMEOUT(4), .TOW(8))
        dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
    rv32i_hazard_ctrl_mc #(.FWD_EN(0), .CNTW(4), .TIMEOUT(0), .TOW(8))
        dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));

    typedef struct {
        bit       rst;
        bit [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        bit       rwe, rwm, rww, load, pcsrc, imrdy, dreq, drdy;
    } stim_t;
    typedef struct { bit waiting; int wcnt; bit err; longint sc, fc, lc; } mstate_t;
    // ctl = {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,TakeBranchE,MemWaitM,MemErr}
    typedef struct { bit [1:0] fa, fb; bit [9:0] ctl; longint sc, fc, lc; bit lu_inc; } exp_t;

    exp_t    qa[$], qb[$];
    exp_t    ea, eb;
    mstate_t ma, mb;
    int      total = 0;
    int      bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit [1:0] fwd_ref(input bit [4:0] rs, input stim_t s);
        if (rs != 0 && s.rwm && rs == s.rdm) return 2'b10;
        if (rs != 0 && s.rww && rs == s.rdw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit dep(input bit [4:0] rs, input stim_t s);
        return rs != 0 && ((s.rwe && rs == s.rde) || (s.rwm && rs == s.rdm));
    endfunction

    function automatic exp_t predict(input stim_t s, input mstate_t m, input bit fwd);
        exp_t e;
        bit mem, raw, sf, sd, se, sm, fd, fe, fw, tb;
        {sf, sd, se, sm, fd, fe, fw, tb} = '0;
        e.lu_inc = 0;
        mem = s.dreq && !s.drdy;
        raw = fwd ? (s.load && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde))
                  : (dep(s.rs1d, s) || dep(s.rs2d, s));
        if (mem)            begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
        else if (s.pcsrc)   begin tb = 1; fd = 1; fe = 1; sf = !s.imrdy; end
        else if (raw)       begin sf = 1; sd = 1; fe = 1; e.lu_inc = s.load; end
        else if (!s.imrdy)  begin sf = 1; fd = 1; end
        e.fa  = fwd ? fwd_ref(s.rs1e, s) : 2'b00;
        e.fb  = fwd ? fwd_ref(s.rs2e, s) : 2'b00;
        e.ctl = {sf, sd, se, sm, fd, fe, fw, tb, m.waiting, m.err};
        e.sc  = m.sc;
        e.fc  = m.fc;
        e.lc  = m.lc;
        return e;
    endfunction

    function automatic mstate_t advance(input stim_t s, input exp_t e, input mstate_t m,
                                        input longint cmax, input int timeout);
        mstate_t n = m;
        if (s.rst) return '{waiting: 0, wcnt: 0, err: 0, sc: 0, fc: 0, lc: 0};
        if (e.ctl[9] || e.ctl[8] || e.ctl[6]) n.sc = (m.sc < cmax) ? m.sc + 1 : cmax;
        if (e.ctl[2]) n.fc = (m.fc < cmax) ? m.fc + 1 : cmax;
        if (e.lu_inc) n.lc = (m.lc < cmax) ? m.lc + 1 : cmax;
        if (timeout != 0 && m.wcnt == timeout) n.err = 1;
        if (m.waiting) begin
            if (s.drdy) begin n.waiting = 0; n.wcnt = 0; end
            else n.wcnt = (m.wcnt < 255) ? m.wcnt + 1 : 255;
        end else if (s.dreq && !s.drdy) begin
            n.waiting = 1;
        end
        return n;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst;
        if_a.Rs1D = s.rs1d; if_a.Rs2D = s.rs2d; if_a.Rs1E = s.rs1e; if_a.Rs2E = s.rs2e;
        if_a.RdE = s.rde; if_a.RdM = s.rdm; if_a.RdW = s.rdw;
        if_a.RegWriteE = s.rwe; if_a.RegWriteM = s.rwm; if_a.RegWriteW = s.rww;
        if_a.ResultSrcEb0 = s.load; if_a.PCSrcE = s.pcsrc; if_a.IMemReadyF = s.imrdy;
        if_a.DMemReqM = s.dreq; if_a.DMemReadyM = s.drdy;
        if_b.Rs1D = s.rs1d; if_b.Rs2D = s.rs2d; if_b.Rs1E = s.rs1e; if_b.Rs2E = s.rs2e;
        if_b.RdE = s.rde; if_b.RdM = s.rdm; if_b.RdW = s.rdw;
        if_b.RegWriteE = s.rwe; if_b.RegWriteM = s.rwm; if_b.RegWriteW = s.rww;
        if_b.ResultSrcEb0 = s.load; if_b.PCSrcE = s.pcsrc; if_b.IMemReadyF = s.imrdy;
        if_b.DMemReqM = s.dreq; if_b.DMemReadyM = s.drdy;
    endtask

    // One clock of stimulus: drive after the edge, push expectations, advance the models.
    task automatic cyc(input stim_t s);
        exp_t xa, xb;
        @(posedge clk);
        #1;
        apply(s);
        xa = predict(s, ma, 1'b1);
        xb = predict(s, mb, 1'b0);
        qa.push_back(xa);
        qb.push_back(xb);
        ma = advance(s, xa, ma, 64'd65535, 4);
        mb = advance(s, xb, mb, 64'd15, 0);
    endtask

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.imrdy = 1;
        s.drdy  = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(0, 99) == 0);
        s.rs1d  = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
        s.rs1e  = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
        s.rde   = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
        s.rdw   = 5'($urandom_range(0, 3));
        s.rwe   = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
        s.rww   = 1'($urandom_range(0, 1));
        s.load  = ($urandom_range(0, 9) < 3);
        s.pcsrc = ($urandom_range(0, 9) < 2);
        s.imrdy = ($urandom_range(0, 9) < 8);
        s.dreq  = ($urandom_range(0, 9) < 3);
        s.drdy  = ($urandom_range(0, 9) < 6);
        return s;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [9:0] ctl, input logic [63:0] sc, input logic [63:0] fc,
                       input logic [63:0] lc);
        check({tag, ".ForwardAE"}, 64'(fa), 64'(e.fa));
        check({tag, ".ForwardBE"}, 64'(fb), 64'(e.fb));
        check({tag, ".ctl"}, 64'(ctl), 64'(e.ctl));
        check({tag, ".StallCnt"}, sc, e.sc);
        check({tag, ".FlushCnt"}, fc, e.fc);
        check({tag, ".LoadUseCnt"}, lc, e.lc);
    endtask

    // Monitor: pop one expectation per presented cycle, compare mid-cycle.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            cmp("A", ea, if_a.ForwardAE, if_a.ForwardBE,
                {if_a.StallF, if_a.StallD, if_a.StallE, if_a.StallM, if_a.FlushD, if_a.FlushE,
                 if_a.FlushW, if_a.TakeBranchE, if_a.MemWaitM, if_a.MemErr},
                64'(if_a.StallCnt), 64'(if_a.FlushCnt), 64'(if_a.LoadUseCnt));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            cmp("B", eb, if_b.ForwardAE, if_b.ForwardBE,
                {if_b.StallF, if_b.StallD, if_b.StallE, if_b.StallM, if_b.FlushD, if_b.FlushE,
                 if_b.FlushW, if_b.TakeBranchE, if_b.MemWaitM, if_b.MemErr},
                64'(if_b.StallCnt), 64'(if_b.FlushCnt), 64'(if_b.LoadUseCnt));
        end
    end

    initial begin
        stim_t s;
        ma = '{waiting: 0, wcnt: 0, err: 0, sc: 0, fc: 0, lc: 0};
        mb = ma;
        s = idle();
        s.rst = 1;
        apply(s);
        @(posedge clk);
        cyc(s);
        cyc(s);

        // Forwarding priority: M over W, x0 never forwarded, W alone.
        s = idle(); s.rdm = 5; s.rdw = 5; s.rwm = 1; s.rww = 1; s.rs1e = 5; s.rs2e = 5;
        cyc(s);
        s.rs1e = 0;
        cyc(s);
        s.rs1e = 5; s.rwm = 0;
        cyc(s);

        // Load-use hazard for one cycle.
        s = idle(); s.load = 1; s.rde = 7; s.rwe = 1; s.rs2d = 7;
        cyc(s);
        cyc(idle());

        // Three wait cycles with a concurrent branch, then ready.
        s = idle(); s.dreq = 1; s.drdy = 0;
        cyc(s);
        s.pcsrc = 1;
        cyc(s);
        s.pcsrc = 0;
        cyc(s);
        s.drdy = 1;
        cyc(s);
        cyc(idle());

        // Branch with fetch miss.
        s = idle(); s.pcsrc = 1; s.imrdy = 0;
        cyc(s);
        cyc(idle());

        // Stall-only RAW against M.
        s = idle(); s.rwm = 1; s.rdm = 3; s.rs1d = 3; s.rs1e = 3;
        cyc(s);

        // Timeout: seven unready cycles, ready, linger, then reset clears MemErr.
        s = idle(); s.dreq = 1; s.drdy = 0;
        for (int i = 0; i < 7; i++) cyc(s);
        s.drdy = 1;
        cyc(s);
        for (int i = 0; i < 3; i++) cyc(idle());
        s = idle(); s.rst = 1;
        cyc(s);
        cyc(idle());

        // Reset in the middle of a wait.
        s = idle(); s.dreq = 1; s.drdy = 0;
        for (int i = 0; i < 3; i++) cyc(s);
        s.rst = 1;
        cyc(s);
        s.rst = 0; s.drdy = 1;
        cyc(s);

        for (int i = 0; i < 3000; i++) cyc(rand_stim());

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        #1;
        total++;
        if (qa.size() > 0 || qb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
